counter_phut_giay: RTL and testbench
====================================

# counter_phut_giay

Seconds/minutes time-base stage that sits directly upstream of `counter_gio`.
- Divides the system clock to a 1 Hz tick and counts seconds 00–59 and minutes 00–59.
- Drives the four low display digits.
- Generates the `inc_hour` signal consumed by `counter_gio`.
- Provides a debounced minute-adjust button and a seconds-clear button, so the user can set time without disturbing hours.

## Interface
- `CLK_HZ`, default 50_000_000: system clock cycles per second; the prescaler terminal count is `CLK_HZ-1`.
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles a button input must stay stable before its new level is accepted (20 ms at 50 MHz).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-low.
- `btn_inc_min`  in  1  raw KEY input, active-low; each accepted press adds one minute.
- `btn_clr_sec`  in  1  raw KEY input, active-low; each accepted press zeroes seconds and the prescaler.
- `tick_1hz`  out  1  one-cycle pulse, once per second.
- `inc_hour`  out  1  level; high while minute==59 and second==59 (registered).
- `carry_hour`  out  1  one-cycle pulse on the cycle the 59:59→00:00 rollover is committed.
- `bcd_HEX0`  out  4  seconds units.
- `bcd_HEX1`  out  4  seconds tens.
- `bcd_HEX2`  out  4  minutes units.
- `bcd_HEX3`  out  4  minutes tens.

## Operation
- **Reset** (`rst`=0 at clk edge):
  - prescaler, second and minute are 0;
  - all outputs are 0;
  - debouncers are loaded to "released" (1).
- **Prescaler:**
  - counts 0..`CLK_HZ-1`;
  - `tick` is asserted in the cycle the count equals `CLK_HZ-1`, and the count wraps to 0.
- **Seconds:**
  - on tick: 59→0 with sec_carry=1; otherwise +1.
- **Minutes:**
  - next = (minute + sec_carry + min_pulse) mod 60, with a 6-bit sum.
  - `carry_hour` = 1 only when sec_carry=1 and minute was 59 before the update.
  - A button-driven wrap 59→0 never asserts `carry_hour` and never affects hours.
- **Buttons:**
  - each goes through a 2-FF synchronizer, then a stable-count debouncer;
  - a pulse fires on an accepted 1→0 transition only, so holding a button gives exactly one pulse and release gives none.
- **Clear-seconds pulse:**
  - second←0 and prescaler←0;
  - it overrides a tick in the same cycle, so that tick is lost and neither seconds nor minutes advance from it;
  - minute still takes `min_pulse` if one is coincident.
- **Simultaneous tick carry + `min_pulse`:** both are applied (minute +2 mod 60). Example: 58 → 00 with `carry_hour`=1 only if minute was 59, so from 58 no carry.
- **`inc_hour`:** registered compare of the next-state values; high for the entire second 59:59 so that a 1 Hz sampler downstream sees it.
- **BCD:** units = value mod 10, tens = value / 10; both registered with the counters.

## Timing
- All state updates on posedge `clk`; no derived clocks.
- `tick_1hz`, `carry_hour`, `inc_hour` and BCD outputs are registered and all change on the same edge as the counters.
- First `tick_1hz` occurs `CLK_HZ` cycles after reset release.
- Button latency from a raw falling edge held stable:
  - 2 cycles for synchronization;
  - `DEBOUNCE_CYCLES` of stability;
  - 1 cycle for edge detection;
  - 1 cycle to the counter update.
- Bounce shorter than `DEBOUNCE_CYCLES` restarts the stability count and produces no pulse.
- Reset asserted mid-debounce or mid-second: everything returns to reset values on that edge, and no pulse is emitted afterwards for a button already held low.

## Structure
- Shared package `clock_pkg`:
  - `SEC_MAX` = 59, `MIN_MAX` = 59, `HOUR_MAX` = 23;
  - BCD digit width of 4;
  - button active level = 0.
- Sub-module `debounce_btn` (params `DEBOUNCE_CYCLES`):
  - ports: `clk`, `rst`, `btn_raw`, `btn_stable`, `press_pulse`;
  - instantiated twice.
- Top level holds the prescaler, counters, carry logic and BCD registers.

## Test plan
Bench parameters: `CLK_HZ`=10, `DEBOUNCE_CYCLES`=4.
- **Reset then free-run:** 10 cycles → `tick_1hz` pulses once and HEX1:HEX0 = 0:1; after 600 cycles, minutes = 01 and seconds = 00.
- **Rollover:** preload via 59 button presses and run to 59:59 → `inc_hour`=1 for 10 cycles; next tick gives 00:00 with `carry_hour`=1 for exactly 1 cycle, then `inc_hour`=0.
- **Bounce:** toggle `btn_inc_min` low 2 cycles / high 1 cycle three times, then hold low 10 cycles → minute increases by exactly 1; hold for 100 cycles → still +1 only.
- **Button wrap:** minute=59, second=10, press inc → minute=00, seconds unchanged, `carry_hour` stays 0.
- **Coincidence:** at 58:59, align accepted `min_pulse` with the tick → 00:00 and `carry_hour`=0. At 59:59 with clear-seconds coincident with the tick → 59:00, no carry, `inc_hour`=0.
- **Reset mid-operation:** at 12:34, assert `rst` 1 cycle while `btn_inc_min` is held low → all outputs 0; keep holding after release → no increment.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the clock time-base stages.
package clock_pkg;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  localparam int unsigned BCD_W = 4;
  typedef logic [BCD_W-1:0] bcd_t;

  // KEY inputs read 0 while pressed.
  localparam logic BTN_ACTIVE   = 1'b0;
  localparam logic BTN_RELEASED = ~BTN_ACTIVE;

  function automatic bcd_t bcd_units(input logic [5:0] v);
    return BCD_W'(v % 6'd10);
  endfunction

  function automatic bcd_t bcd_tens(input logic [5:0] v);
    return BCD_W'(v / 6'd10);
  endfunction

endpackage

// File: rtl/debounce_btn.sv
// Synchronizes a raw active-low KEY, accepts a new level only after it has
// been stable for DEBOUNCE_CYCLES, and emits one pulse per accepted press.
module debounce_btn
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_stable,
  output logic press_pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [1:0]    vld_q, vld_d;
  logic          armed_q, armed_d;
  logic          stable_q, stable_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Stability counter, arming and edge detection.
  // A key held through reset must not fire: presses are only honoured once
  // the synchronized input has been seen released after reset (armed_q).
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    vld_d    = {vld_q[0], 1'b1};
    armed_d  = armed_q | (vld_q[1] & (sync2_q == BTN_RELEASED));
    pulse_d  = armed_q & (prev_q == BTN_RELEASED) & (stable_q == BTN_ACTIVE);
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and debouncer state; reset loads the released level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= BTN_RELEASED;
      sync2_q  <= BTN_RELEASED;
      vld_q    <= '0;
      armed_q  <= 1'b0;
      stable_q <= BTN_RELEASED;
      prev_q   <= BTN_RELEASED;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      vld_q    <= vld_d;
      armed_q  <= armed_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign btn_stable  = stable_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/counter_phut_giay.sv
// Seconds/minutes time base: 1 Hz prescaler, 00-59 second and minute
// counters, hour-increment signalling and BCD digits for HEX3..HEX0.
module counter_phut_giay
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc_min,
  input  logic       btn_clr_sec,
  output logic       tick_1hz,
  output logic       inc_hour,
  output logic       carry_hour,
  output logic [3:0] bcd_HEX0,
  output logic [3:0] bcd_HEX1,
  output logic [3:0] bcd_HEX2,
  output logic [3:0] bcd_HEX3
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [5:0] SEC_LAST = 6'(SEC_MAX);
  localparam logic [5:0] MIN_LAST = 6'(MIN_MAX);
  localparam logic [5:0] MIN_MOD  = 6'(MIN_MAX + 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic          tick_q, tick_d;
  logic          inc_q, inc_d;
  logic          carry_q, carry_d;
  bcd_t          hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d, hex3_q, hex3_d;

  logic          tick, sec_carry, min_pulse, clr_pulse;
  logic [5:0]    min_sum;
  logic [1:0]    btn_stable_unused;

  debounce_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_inc_min),
    .btn_stable  (btn_stable_unused[0]),
    .press_pulse (min_pulse)
  );

  debounce_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_clr_sec),
    .btn_stable  (btn_stable_unused[1]),
    .press_pulse (clr_pulse)
  );

  // Next-state for prescaler, counters and registered outputs.
  // Clear-seconds wins over a coincident tick, which is then lost entirely.
  always_comb begin
    tick      = (pre_q == PRE_LAST);
    pre_d     = tick ? '0 : pre_q + 1'b1;
    sec_d     = sec_q;
    sec_carry = 1'b0;
    if (clr_pulse) begin
      pre_d = '0;
      sec_d = '0;
    end else if (tick) begin
      if (sec_q == SEC_LAST) begin
        sec_d     = '0;
        sec_carry = 1'b1;
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
    min_sum = min_q + {5'd0, sec_carry} + {5'd0, min_pulse};
    min_d   = (min_sum >= MIN_MOD) ? min_sum - MIN_MOD : min_sum;
    tick_d  = tick & ~clr_pulse;
    carry_d = sec_carry & (min_q == MIN_LAST);
    inc_d   = (min_d == MIN_LAST) && (sec_d == SEC_LAST);
    hex0_d  = bcd_units(sec_d);
    hex1_d  = bcd_tens(sec_d);
    hex2_d  = bcd_units(min_d);
    hex3_d  = bcd_tens(min_d);
  end

  // State and output registers, all committed on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q   <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      tick_q  <= 1'b0;
      inc_q   <= 1'b0;
      carry_q <= 1'b0;
      hex0_q  <= '0;
      hex1_q  <= '0;
      hex2_q  <= '0;
      hex3_q  <= '0;
    end else begin
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      tick_q  <= tick_d;
      inc_q   <= inc_d;
      carry_q <= carry_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
      hex3_q  <= hex3_d;
    end
  end

  assign tick_1hz   = tick_q;
  assign inc_hour   = inc_q;
  assign carry_hour = carry_q;
  assign bcd_HEX0   = hex0_q;
  assign bcd_HEX1   = hex1_q;
  assign bcd_HEX2   = hex2_q;
  assign bcd_HEX3   = hex3_q;

endmodule

// File: tb/tb_counter_phut_giay.sv
// Bench for counter_phut_giay with a small clock and debounce window.
// Reference model keeps time as seconds-into-the-hour (0..3599).
module tb_counter_phut_giay;

  localparam int CLK_HZ = 10;
  localparam int DB     = 4;
  localparam int PLEN   = DB + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_inc_min;
  logic       btn_clr_sec;
  logic       tick_1hz, inc_hour, carry_hour;
  logic [3:0] bcd_HEX0, bcd_HEX1, bcd_HEX2, bcd_HEX3;

  int checks = 0;
  int errors = 0;
  int nav_bad = 0;

  counter_phut_giay #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_inc_min (btn_inc_min),
    .btn_clr_sec (btn_clr_sec),
    .tick_1hz    (tick_1hz),
    .inc_hour    (inc_hour),
    .carry_hour  (carry_hour),
    .bcd_HEX0    (bcd_HEX0),
    .bcd_HEX1    (bcd_HEX1),
    .bcd_HEX2    (bcd_HEX2),
    .bcd_HEX3    (bcd_HEX3)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_t;       // seconds into the hour
  int m_phase;   // clock cycles since the last second boundary
  bit e_tick, e_carry;
  bit db_level[2];
  int db_run[2];
  bit db_armed[2];
  bit pend[2][4];  // accepted presses travelling towards the counter

  task automatic m_reset();
    m_t = 0; m_phase = 0; e_tick = 0; e_carry = 0;
    for (int b = 0; b < 2; b++) begin
      db_level[b] = 1; db_run[b] = 0; db_armed[b] = 0;
      for (int k = 0; k < 4; k++) pend[b][k] = 0;
    end
  endtask

  task automatic model_edge();
    bit raw[2];
    bit apply[2];
    bit tick_now;
    int t0;
    raw[0] = btn_inc_min;
    raw[1] = btn_clr_sec;
    if (!rst) begin
      m_reset();
      return;
    end
    for (int b = 0; b < 2; b++) begin
      apply[b] = pend[b][3];
      for (int k = 3; k > 0; k--) pend[b][k] = pend[b][k-1];
      pend[b][0] = 0;
      if (raw[b]) db_armed[b] = 1;
      if (raw[b] != db_level[b]) begin
        db_run[b]++;
        if (db_run[b] == DB) begin
          db_level[b] = raw[b];
          db_run[b] = 0;
          pend[b][0] = (raw[b] == 0) && db_armed[b];
        end
      end else begin
        db_run[b] = 0;
      end
    end
    tick_now = (m_phase == CLK_HZ - 1);
    t0 = m_t;
    if (apply[1]) begin
      m_phase = 0;
      m_t = (m_t / 60) * 60;
      e_tick = 0;
      e_carry = 0;
    end else begin
      m_phase = tick_now ? 0 : m_phase + 1;
      e_tick = tick_now;
      e_carry = tick_now && (t0 == 3599);
      if (tick_now) m_t++;
    end
    if (apply[0]) m_t += 60;
    m_t = m_t % 3600;
  endtask

  function automatic logic [18:0] mexp();
    int mm, ss;
    mm = m_t / 60;
    ss = m_t % 60;
    return {e_tick, (m_t == 3599), e_carry, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [18:0] dut_obs();
    return {tick_1hz, inc_hour, carry_hour, bcd_HEX3, bcd_HEX2, bcd_HEX1, bcd_HEX0};
  endfunction

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- navigation (stimulus only) ----------------
  task automatic nav_press(input int b);
    for (int i = 0; i < 2 * PLEN; i++) begin
      if (b == 0) btn_inc_min = (i < PLEN) ? 1'b0 : 1'b1;
      else        btn_clr_sec = (i < PLEN) ? 1'b0 : 1'b1;
      cyc();
      if (dut_obs() !== mexp()) nav_bad++;
    end
  endtask

  task automatic goto_state(input int tmin, input int tsec, input int tph, output bit ok);
    int budget;
    budget = 30000;
    ok = 0;
    nav_bad = 0;
    while (budget > 0 && !ok) begin
      if (m_t / 60 == tmin && m_t % 60 == tsec && (tph < 0 || m_phase == tph)) begin
        ok = 1;
      end else if (m_t % 60 >= 50 && (m_t / 60 != tmin || m_t % 60 > tsec)) begin
        nav_press(1);
        budget -= 2 * PLEN;
      end else if (m_t / 60 != tmin) begin
        nav_press(0);
        budget -= 2 * PLEN;
      end else begin
        cyc();
        if (dut_obs() !== mexp()) nav_bad++;
        budget--;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; btn_inc_min = 1'b1; btn_clr_sec = 1'b1;
    repeat (3) cyc();
    checks++;
    if (dut_obs() !== 19'd0) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", dut_obs(), 19'd0);
    end
    rst = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      cyc();
      checks++;
      if (dut_obs() !== mexp()) begin
        errors++; $display("FAIL freerun_lockstep cyc=%0d got=%h exp=%h", i, dut_obs(), mexp());
      end
      if (i == 10) begin
        checks++;
        if ({tick_1hz, bcd_HEX1, bcd_HEX0} !== {1'b1, 4'd0, 4'd1}) begin
          errors++; $display("FAIL first_tick got=%h exp=%h", {tick_1hz, bcd_HEX1, bcd_HEX0}, {1'b1, 4'd0, 4'd1});
        end
      end
    end
    checks++;
    if ({bcd_HEX3, bcd_HEX2, bcd_HEX1, bcd_HEX0} !== 16'h0100) begin
      errors++; $display("FAIL one_minute got=%h exp=0100", {bcd_HEX3, bcd_HEX2, bcd_HEX1, bcd_HEX0});
    end
  endtask

  task automatic test_rollover();
    bit ok;
    goto_state(59, 59, 0, ok);
    checks++;
    if (!ok || nav_bad !== 0) begin
      errors++; $display("FAIL rollover_setup got ok=%0d bad=%0d exp ok=1 bad=0", ok, nav_bad);
    end
    checks++;
    if ({inc_hour, carry_hour} !== 2'b10) begin
      errors++; $display("FAIL rollover_inc_start got=%b exp=10", {inc_hour, carry_hour});
    end
    for (int i = 1; i < CLK_HZ; i++) begin
      cyc();
      checks++;
      if ({inc_hour, carry_hour, dut_obs()} !== {2'b10, mexp()}) begin
        errors++; $display("FAIL rollover_inc_hold cyc=%0d got=%h exp=%h", i, {inc_hour, carry_hour, dut_obs()}, {2'b10, mexp()});
      end
    end
    cyc();
    checks++;
    if (dut_obs() !== {3'b101, 16'h0000}) begin
      errors++; $display("FAIL rollover_commit got=%h exp=%h", dut_obs(), {3'b101, 16'h0000});
    end
    cyc();
    checks++;
    if ({carry_hour, inc_hour} !== 2'b00 || dut_obs() !== mexp()) begin
      errors++; $display("FAIL rollover_after got=%h exp=%h", dut_obs(), mexp());
    end
  endtask

  task automatic test_bounce();
    bit ok;
    goto_state(30, 0, -1, ok);
    checks++;
    if (!ok || nav_bad !== 0) begin
      errors++; $display("FAIL bounce_setup got ok=%0d bad=%0d exp ok=1 bad=0", ok, nav_bad);
    end
    for (int i = 0; i < 9 + 100 + PLEN; i++) begin
      if (i < 9) btn_inc_min = ((i % 3) == 2) ? 1'b1 : 1'b0;
      else       btn_inc_min = (i < 109) ? 1'b0 : 1'b1;
      cyc();
      checks++;
      if (dut_obs() !== mexp()) begin
        errors++; $display("FAIL bounce_lockstep cyc=%0d got=%h exp=%h", i, dut_obs(), mexp());
      end
      if (i == 8 || i == 18 || i == 108) begin
        checks++;
        if ({bcd_HEX3, bcd_HEX2} !== ((i == 8) ? 8'h30 : 8'h31)) begin
          errors++; $display("FAIL bounce_minute cyc=%0d got=%h exp=%h", i, {bcd_HEX3, bcd_HEX2}, (i == 8) ? 8'h30 : 8'h31);
        end
      end
    end
  endtask

  task automatic test_button_wrap();
    bit ok;
    int carry_seen;
    carry_seen = 0;
    goto_state(59, 10, -1, ok);
    checks++;
    if (!ok || nav_bad !== 0) begin
      errors++; $display("FAIL wrap_setup got ok=%0d bad=%0d exp ok=1 bad=0", ok, nav_bad);
    end
    for (int i = 0; i < 2 * PLEN; i++) begin
      btn_inc_min = (i < PLEN) ? 1'b0 : 1'b1;
      cyc();
      if (carry_hour) carry_seen++;
      checks++;
      if (dut_obs() !== mexp()) begin
        errors++; $display("FAIL wrap_lockstep cyc=%0d got=%h exp=%h", i, dut_obs(), mexp());
      end
    end
    checks++;
    if ({bcd_HEX3, bcd_HEX2, bcd_HEX1} !== 12'h001 || carry_seen != 0) begin
      errors++; $display("FAIL wrap_result got=%h carries=%0d exp=001 carries=0", {bcd_HEX3, bcd_HEX2, bcd_HEX1}, carry_seen);
    end
  endtask

  task automatic test_coincidence();
    bit ok;
    goto_state(58, 59, CLK_HZ - (DB + 4), ok);
    checks++;
    if (!ok || nav_bad !== 0) begin
      errors++; $display("FAIL coinc_min_setup got ok=%0d bad=%0d exp ok=1 bad=0", ok, nav_bad);
    end
    for (int i = 0; i < 2 * PLEN; i++) begin
      btn_inc_min = (i < PLEN) ? 1'b0 : 1'b1;
      cyc();
      checks++;
      if (dut_obs() !== mexp()) begin
        errors++; $display("FAIL coinc_min_lockstep cyc=%0d got=%h exp=%h", i, dut_obs(), mexp());
      end
      if (i == DB + 3) begin
        checks++;
        if (dut_obs() !== {3'b100, 16'h0000}) begin
          errors++; $display("FAIL coinc_min_tick got=%h exp=%h", dut_obs(), {3'b100, 16'h0000});
        end
      end
    end
    goto_state(59, 59, CLK_HZ - (DB + 4), ok);
    checks++;
    if (!ok || nav_bad !== 0) begin
      errors++; $display("FAIL coinc_clr_setup got ok=%0d bad=%0d exp ok=1 bad=0", ok, nav_bad);
    end
    for (int i = 0; i < 2 * PLEN; i++) begin
      btn_clr_sec = (i < PLEN) ? 1'b0 : 1'b1;
      cyc();
      checks++;
      if (dut_obs() !== mexp()) begin
        errors++; $display("FAIL coinc_clr_lockstep cyc=%0d got=%h exp=%h", i, dut_obs(), mexp());
      end
      if (i == DB + 3) begin
        checks++;
        if (dut_obs() !== {3'b000, 16'h5900}) begin
          errors++; $display("FAIL coinc_clr_tick got=%h exp=%h", dut_obs(), {3'b000, 16'h5900});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    goto_state(12, 34, -1, ok);
    checks++;
    if (!ok || nav_bad !== 0) begin
      errors++; $display("FAIL rstmid_setup got ok=%0d bad=%0d exp ok=1 bad=0", ok, nav_bad);
    end
    btn_inc_min = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (dut_obs() !== 19'd0) begin
      errors++; $display("FAIL rstmid_zero got=%h exp=%h", dut_obs(), 19'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      checks++;
      if (dut_obs() !== mexp()) begin
        errors++; $display("FAIL rstmid_lockstep cyc=%0d got=%h exp=%h", i, dut_obs(), mexp());
      end
    end
    checks++;
    if ({bcd_HEX3, bcd_HEX2} !== 8'h00) begin
      errors++; $display("FAIL rstmid_no_inc got=%h exp=00", {bcd_HEX3, bcd_HEX2});
    end
    btn_inc_min = 1'b1;
    repeat (PLEN) cyc();
  endtask

  task automatic test_back_to_back();
    int   left[2];
    logic lvl[2];
    left = '{0, 0};
    lvl  = '{1'b1, 1'b1};
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (left[b] == 0) begin
          lvl[b]  = ~lvl[b];
          left[b] = $urandom_range(1, 12);
        end
        left[b]--;
      end
      btn_inc_min = lvl[0];
      btn_clr_sec = ($urandom_range(0, 3) == 0) ? lvl[1] : 1'b1;
      rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      cyc();
      checks++;
      if (dut_obs() !== mexp()) begin
        errors++; $display("FAIL random_lockstep cyc=%0d got=%h exp=%h", c, dut_obs(), mexp());
      end
    end
    rst = 1'b1; btn_inc_min = 1'b1; btn_clr_sec = 1'b1;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_rollover();
    test_bounce();
    test_button_wrap();
    test_coincidence();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog");
  end

endmodule
